// File: rtl/seg7_disp_arbiter.sv
// seg7_disp_arbiter: round-robin arbiter with minimum hold time, sharing one
// multiplexed four-digit seven-segment display between three requesters.
module seg7_disp_arbiter #(
    parameter int SCAN_DIV   = 249999,
    parameter int HOLD_TICKS = 200
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [47:0] req_data,
    input  logic [11:0] req_dot,
    output logic [2:0]  gnt,
    output logic [2:0]  ack,
    output logic [1:0]  seg_select,
    output logic [3:0]  bin,
    output logic        dot
);
    localparam int CW = $clog2(SCAN_DIV + 2);
    localparam int HW = $clog2(HOLD_TICKS + 2);
    localparam logic [CW-1:0] SCAN_MAX = CW'(SCAN_DIV);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    scan_idx;
    logic          tick;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [1:0]    rr_ptr, rr_nxt, owner, owner_nxt, off, win, src;
    logic [2:0]    rot, sum, gnt_nxt, ack_nxt;
    logic [15:0]   disp_reg, disp_nxt, src_data;
    logic [3:0]    dot_reg, dot_nxt, src_dot;
    logic          own_req, release_own;

    assign tick = scan_cnt == SCAN_MAX;

    // Display outputs are all registered from the same scan index so they stay aligned.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            scan_cnt   <= '0;
            scan_idx   <= '0;
            seg_select <= '0;
            bin        <= '0;
            dot        <= 1'b0;
        end else begin
            scan_cnt   <= tick ? '0 : scan_cnt + 1'b1;
            scan_idx   <= scan_idx + 2'(tick);
            seg_select <= scan_idx;
            bin        <= disp_reg[{scan_idx, 2'b00} +: 4];
            dot        <= dot_reg[scan_idx];
        end
    end

    // Rotate req so bit 0 is the requester at rr_ptr; the first set bit gives the offset.
    always_comb begin
        rot = rr_ptr == 2'd1 ? {req[0], req[2:1]} :
              rr_ptr == 2'd2 ? {req[1:0], req[2]} : req;
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : 2'd2;
        sum = {1'b0, rr_ptr} + {1'b0, off};
        win = sum >= 3'd3 ? 2'(sum - 3'd3) : sum[1:0];
        src = state == IDLE ? win : owner;
        src_data = src == 2'd0 ? req_data[15:0] : src == 2'd1 ? req_data[31:16] : req_data[47:32];
        src_dot  = src == 2'd0 ? req_dot[3:0]   : src == 2'd1 ? req_dot[7:4]     : req_dot[11:8];
        own_req     = |(req & gnt);
        release_own = hold_cnt == HOLD_MAX && (!own_req || |(req & ~gnt));
        state_nxt = state;
        gnt_nxt   = gnt;
        ack_nxt   = '0;
        hold_nxt  = hold_cnt;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        disp_nxt  = disp_reg;
        dot_nxt   = dot_reg;
        if (state == IDLE) begin
            if (|req) begin
                state_nxt = OWN;
                owner_nxt = win;
                gnt_nxt   = 3'b001 << win;
                ack_nxt   = 3'b001 << win;
                hold_nxt  = '0;
                disp_nxt  = src_data;
                dot_nxt   = src_dot;
            end
        end else begin
            if (own_req) begin
                disp_nxt = src_data;
                dot_nxt  = src_dot;
            end
            if (release_own) begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                rr_nxt    = owner == 2'd2 ? 2'd0 : owner + 2'd1;
            end else if (tick && hold_cnt != HOLD_MAX) begin
                hold_nxt = hold_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            ack      <= '0;
            hold_cnt <= '0;
            rr_ptr   <= '0;
            owner    <= '0;
            disp_reg <= '0;
            dot_reg  <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            ack      <= ack_nxt;
            hold_cnt <= hold_nxt;
            rr_ptr   <= rr_nxt;
            owner    <= owner_nxt;
            disp_reg <= disp_nxt;
            dot_reg  <= dot_nxt;
        end
    end
endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// tb_seg7_disp_arbiter: directed scenarios plus random traffic, checked every
// cycle against a behavioural model of the arbiter and display scan.
module tb_seg7_disp_arbiter;
    localparam int SD = 4;
    localparam int HT = 3;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [47:0] req_data = '0;
    logic [11:0] req_dot = '0;
    logic [2:0]  gnt, ack;
    logic [1:0]  seg_select;
    logic [3:0]  bin;
    logic        dot;

    seg7_disp_arbiter #(.SCAN_DIV(SD), .HOLD_TICKS(HT)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .req(req), .req_data(req_data),
        .req_dot(req_dot), .gnt(gnt), .ack(ack), .seg_select(seg_select),
        .bin(bin), .dot(dot)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner as an int (-1 = none), ticks from a cycle count.
    int         m_cnt, m_idx, m_owner, m_hold, m_rr;
    logic [2:0] m_ack;
    logic [1:0] m_sel;
    logic [3:0] m_bin;
    logic       m_dot;
    logic [15:0] m_disp;
    logic [3:0] m_dotr;
    bit         m_valid = 0;

    always @(posedge clk_sys) begin
        bit tk;
        bit others;
        if (!rst_n) begin
            m_valid = 1; m_cnt = 0; m_idx = 0; m_owner = -1; m_hold = 0; m_rr = 0;
            m_ack = 0; m_sel = 0; m_bin = 0; m_dot = 0; m_disp = 0; m_dotr = 0;
        end else begin
            tk = (m_cnt == SD);
            m_sel = m_idx[1:0];
            m_bin = m_disp[4*m_idx +: 4];
            m_dot = m_dotr[m_idx];
            m_cnt = tk ? 0 : m_cnt + 1;
            if (tk) m_idx = (m_idx + 1) % 4;
            m_ack = 0;
            if (m_owner < 0) begin
                for (int k = 0; k < 3; k++)
                    if (m_owner < 0 && req[(m_rr + k) % 3]) m_owner = (m_rr + k) % 3;
                if (m_owner >= 0) begin
                    m_ack  = 3'(1 << m_owner);
                    m_hold = 0;
                    m_disp = req_data[16*m_owner +: 16];
                    m_dotr = req_dot[4*m_owner +: 4];
                end
            end else begin
                others = 0;
                for (int k = 0; k < 3; k++)
                    if (k != m_owner && req[k]) others = 1;
                if (req[m_owner]) begin
                    m_disp = req_data[16*m_owner +: 16];
                    m_dotr = req_dot[4*m_owner +: 4];
                end
                if (m_hold == HT && (!req[m_owner] || others)) begin
                    m_rr = (m_owner + 1) % 3;
                    m_owner = -1;
                end else if (tk && m_hold < HT) begin
                    m_hold++;
                end
            end
        end
    end

    always @(posedge clk_sys) begin
        #2;
        if (m_valid) begin
            chk("gnt", 32'(gnt), m_owner < 0 ? 32'd0 : 32'(1 << m_owner));
            chk("ack", 32'(ack), 32'(m_ack));
            chk("seg_select", 32'(seg_select), 32'(m_sel));
            chk("bin", 32'(bin), 32'(m_bin));
            chk("dot", 32'(dot), 32'(m_dot));
        end
    end

    task automatic do_reset();
        @(negedge clk_sys) rst_n = 1'b0;
        @(negedge clk_sys) rst_n = 1'b1;
    endtask

    task automatic edge_sample();
        @(posedge clk_sys);
        #2;
    endtask

    initial begin
        logic [3:0] exp_bin [4];
        logic       exp_dot [4];
        logic [15:0] v;
        int order[$];
        int e;
        logic [2:0] prev;

        // Scan with no requests
        req = 0;
        do_reset();
        for (int i = 1; i <= 21; i++) begin
            edge_sample();
            if (i == 5)  chk("scan_e5", 32'(seg_select), 0);
            if (i == 6)  chk("scan_e6", 32'(seg_select), 1);
            if (i == 11) chk("scan_e11", 32'(seg_select), 2);
            if (i == 16) chk("scan_e16", 32'(seg_select), 3);
            if (i == 21) begin
                chk("scan_e21", 32'(seg_select), 0);
                chk("scan_bin0", 32'(bin), 0);
                chk("scan_dot0", 32'(dot), 0);
            end
        end

        // Single grant
        do_reset();
        req = 3'b010; req_data = {16'h0000, 16'hA5C3, 16'h0000}; req_dot = 12'h010;
        edge_sample();
        chk("single_gnt", 32'(gnt), 32'h2);
        chk("single_ack", 32'(ack), 32'h2);
        edge_sample();
        chk("single_ack_pulse", 32'(ack), 0);
        exp_bin = '{4'h3, 4'hC, 4'h5, 4'hA};
        exp_dot = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 24; i++) begin
            edge_sample();
            if (i % 5 == 0) begin
                chk("single_bin", 32'(bin), 32'(exp_bin[seg_select]));
                chk("single_dot", 32'(dot), 32'(exp_dot[seg_select]));
            end
        end
        chk("single_keep", 32'(gnt), 32'h2);

        // Round-robin with all requesting
        @(negedge clk_sys) rst_n = 1'b0;
        req = 3'b111;
        @(negedge clk_sys) rst_n = 1'b1;
        prev = 0;
        for (int i = 0; i < 200 && order.size() < 4; i++) begin
            edge_sample();
            if (ack != 0) begin
                if (order.size() > 0) chk("rr_gap", 32'(prev), 0);
                order.push_back(ack == 3'b001 ? 0 : ack == 3'b010 ? 1 : 2);
            end
            prev = gnt;
        end
        chk("rr_count", 32'(order.size()), 4);
        if (order.size() == 4) begin
            chk("rr_o0", 32'(order[0]), 0);
            chk("rr_o1", 32'(order[1]), 1);
            chk("rr_o2", 32'(order[2]), 2);
            chk("rr_o3", 32'(order[3]), 0);
        end

        // Minimum hold after the owner drops its request
        req = 0;
        do_reset();
        req = 3'b001; req_data = 48'h0000_0000_1234; req_dot = 0;
        repeat (6) @(negedge clk_sys);
        req = 0; req_data = 48'hFFFF_FFFF_FFFF; req_dot = 12'hFFF;
        v = 16'h1234;
        e = 7;
        for (int i = 0; i < 40; i++) begin
            edge_sample();
            if (gnt != 3'b001) break;
            chk("hold_frozen_bin", 32'(bin), 32'(v[4*seg_select +: 4]));
            chk("hold_frozen_dot", 32'(dot), 0);
            e++;
        end
        chk("hold_release_edge", 32'(e), 16);
        chk("hold_release_gnt", 32'(gnt), 0);

        // No preemption of owner 2
        req = 0;
        do_reset();
        req = 3'b100; req_data = 48'h9876_0000_0000;
        repeat (6) @(negedge clk_sys);
        req = 3'b101;
        e = 7;
        for (int i = 0; i < 40; i++) begin
            edge_sample();
            if (gnt != 3'b100) break;
            e++;
        end
        chk("nopre_release_edge", 32'(e), 16);
        chk("nopre_gap", 32'(gnt), 0);
        edge_sample();
        chk("nopre_gnt0", 32'(gnt), 32'h1);
        chk("nopre_ack0", 32'(ack), 32'h1);

        // Reset while owning
        req = 0;
        do_reset();
        req = 3'b001; req_data = 48'h0000_0000_7777; req_dot = 12'h00F;
        repeat (8) @(negedge clk_sys);
        chk("rst_pre_bin", 32'(bin), 7);
        rst_n = 1'b0;
        edge_sample();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_sel", 32'(seg_select), 0);
        chk("rst_bin", 32'(bin), 0);
        chk("rst_dot", 32'(dot), 0);
        @(negedge clk_sys) rst_n = 1'b1;
        edge_sample();
        chk("rst_regrant_gnt", 32'(gnt), 32'h1);
        chk("rst_regrant_ack", 32'(ack), 32'h1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sys);
            req_data = 48'({$urandom(), $urandom()});
            req_dot  = 12'($urandom());
            if ($urandom_range(0, 5) == 0) req = req ^ 3'(1 << $urandom_range(0, 2));
            rst_n = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk_sys) rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_disp_arbiter.md
SEG7_DISP_ARBITER -- requirements
Module: seg7_disp_arbiter

Interface
REQ-001 Parameter SCAN_DIV, default 249999, is the terminal count of the scan-tick divider; one tick every SCAN_DIV+1 clk_sys cycles (200 Hz at 50 MHz).
REQ-002 Parameter HOLD_TICKS, default 200, is the minimum ownership time in scan ticks (1 s).
REQ-003 clk_sys  input  1  system clock (50 MHz); the single clock of the block.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  3  display request per requester; req[i] is level-sensitive.
REQ-006 req_data  input  48  four-digit hex value per requester; requester i uses bits [16i+15:16i].
REQ-007 req_dot  input  12  four decimal points per requester; requester i uses bits [4i+3:4i].
REQ-008 gnt  output  3  one-hot owner indication; all zero when there is no owner.
REQ-009 ack  output  3  one-cycle pulse on the cycle gnt[i] first asserts.
REQ-010 seg_select  output  2  digit index to the seven-segment decoder.
REQ-011 bin  output  4  nibble for the selected digit.
REQ-012 dot  output  1  decimal point for the selected digit.

Function
REQ-013 The scan counter shall count 0..SCAN_DIV and wrap; tick shall pulse for one cycle when the counter equals SCAN_DIV.
REQ-014 The internal scan index shall increment on each tick and wrap from 3 to 0.
REQ-015 seg_select, bin and dot shall all be registered and update on the same edge, one cycle after the scan index changes, so the three are always mutually aligned.
REQ-016 Digit mapping: index k drives bin = disp_reg[4k+3:4k] and dot = dot_reg[k].
REQ-017 The FSM shall have two states: IDLE (gnt=0) and OWN (exactly one gnt bit set).
REQ-018 In IDLE with req != 0: the winner is the first set req bit searched upward from rr_ptr, modulo 3; on the next edge the FSM enters OWN, gnt and ack assert for the winner, hold_cnt clears, and disp_reg/dot_reg load the winner's data.
REQ-019 In IDLE with req == 0: the FSM shall stay in IDLE and disp_reg/dot_reg shall retain their values.
REQ-020 In OWN, disp_reg/dot_reg shall reload from the owner's inputs on every cycle in which the owner's req is high; otherwise they shall hold.
REQ-021 In OWN, hold_cnt shall increment on each tick and saturate at HOLD_TICKS.
REQ-022 Release condition: hold_cnt == HOLD_TICKS and either the owner's req is low or any other req bit is high.
REQ-023 On release, the next edge shall clear gnt, set rr_ptr = (owner+1) mod 3 and enter IDLE; re-arbitration takes place from IDLE, giving a one-cycle bubble between owners.
REQ-024 If the owner's req drops before hold expiry, gnt shall remain set and the last data shall stay displayed until expiry.
REQ-025 If only the owner requests, ownership shall continue indefinitely.
REQ-026 Other requesters shall never preempt the owner before hold expiry.
REQ-027 If a tick coincides with release, the tick shall advance scanning only; hold_cnt is a don't-care after leaving OWN.

Reset
REQ-028 When rst_n is low at an edge, the following shall clear on that edge: scan counter, scan index, seg_select, bin, dot, gnt, ack, hold_cnt, rr_ptr, disp_reg, dot_reg; the FSM shall enter IDLE.
REQ-029 A reset asserted during OWN shall drop gnt on the same edge with no ack, and no data shall be latched on that edge.
REQ-030 After rst_n rises, the first tick shall occur SCAN_DIV+1 cycles later.

Verification (SCAN_DIV=4, HOLD_TICKS=3)
REQ-031 Scan: no requests after reset -> tick every 5 cycles; seg_select sequence 0,1,2,3,0; bin=0 and dot=0 throughout.
REQ-032 Single grant: req=3'b010, req_data[31:16]=16'hA5C3, req_dot[7:4]=4'b0001 -> one cycle later gnt=3'b010 with a single-cycle ack[1]; seg_select 0..3 shows bin 3,C,5,A with dot 1,0,0,0.
REQ-033 Round-robin: req=3'b111 held from reset -> owners in order 0,1,2,0; each owner is held for 3 ticks plus a 1-cycle gap with gnt=0.
REQ-034 Minimum hold: owner 0 drops req 1 tick after grant -> gnt[0] stays high until the 3rd tick; displayed value stays frozen; then the FSM returns to IDLE.
REQ-035 No preemption: owner 2 holding, req[0] rises at tick 1 -> gnt[0] asserts only after the 3rd tick plus a 1-cycle gap.
REQ-036 Reset mid-OWN: rst_n low for 1 cycle during OWN -> all outputs 0 on the next edge; after release, a pending req=3'b001 is granted starting from rr_ptr=0.
